fetch_unit: RTL and testbench

Instruction fetch sequencer sitting between the program counter and instruction memory. Reads the current PC, issues one memory read per instruction over a valid/ready request channel, and latches the returned word into an instruction register for decode. Drives the PC's 2-bit `pc_handle` control (00 hold, 01 increment) so the PC advances exactly once per fetched instruction. Flags a sticky fault if memory never responds.

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: fetch sequencer that reads PC, issues one memory read per instruction and
// latches the returned word for decode, stepping the PC once per fetched instruction.
module fetch_unit #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [1:0]         pc_handle,
  output logic               mem_req_valid,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_req_ready,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready,
  output logic               fault
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ir_pc_q, ir_pc_d;
  logic [INSTR_W-1:0] ir_data_q, ir_data_d;
  logic ir_valid_q, ir_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ir_pc_d    = ir_pc_q;
    ir_data_d  = ir_data_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = run ? REQ : IDLE;
        addr_d  = run ? pc_in : addr_q;
      end
      REQ: begin
        state_d = mem_req_ready ? WAIT : REQ;
        cnt_d   = mem_req_ready ? '0 : cnt_q;
      end
      // a response on the last allowed cycle takes priority over the timeout
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d    = HOLD;
          ir_data_d  = mem_rsp_data;
          ir_pc_d    = addr_q;
          ir_valid_d = 1'b1;
        end else begin
          state_d = (cnt_q >= LAST) ? FAULT : WAIT;
          cnt_d   = (cnt_q == MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end
      HOLD: begin
        state_d    = ir_ready ? (run ? REQ : IDLE) : HOLD;
        addr_d     = (ir_ready && run) ? pc_in : addr_q;
        ir_valid_d = ir_ready ? 1'b0 : ir_valid_q;
      end
      default: begin
        state_d    = FAULT;
        ir_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ir_pc_q    <= '0;
      ir_data_q  <= '0;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ir_pc_q    <= ir_pc_d;
      ir_data_q  <= ir_data_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
    end
  end
  assign pc_handle     = {1'b0, state_q == WAIT && mem_rsp_valid};
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr  = addr_q;
  assign ir_valid      = ir_valid_q;
  assign ir_data       = ir_data_q;
  assign ir_pc         = ir_pc_q;
  assign fault         = state_q == FAULT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized fetch sequences against a transaction-level PC/IR model.
module tb_fetch_unit;
  localparam int AW = 24;
  localparam int IW = 32;
  logic clk = 0, rst = 1, run = 0, mem_req_ready = 0, mem_rsp_valid = 0, ir_ready = 1;
  logic pc_ld = 1;
  logic [AW-1:0] pc_ld_val = 24'h000010;
  logic [AW-1:0] pc;
  logic [IW-1:0] mem_rsp_data = 0;
  logic [1:0] pc_handle;
  logic mem_req_valid, ir_valid, fault;
  logic [AW-1:0] mem_req_addr, ir_pc;
  logic [IW-1:0] ir_data;
  int pulses = 0;
  int passed = 0, total = 0;
  int p0, r, d, h;
  logic [AW-1:0] exp_pc;
  logic [IW-1:0] d1, d2, dr;

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_in(pc), .pc_handle(pc_handle),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  // the program counter this block drives
  always @(posedge clk) begin
    if (pc_ld) pc <= pc_ld_val;
    else if (pc_handle == 2'b01) pc <= pc + 24'd1;
    if (pc_handle == 2'b01) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_data", ir_data, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_pc_handle", pc_handle, 0);
    chk("rst_fault", fault, 0);
    // basic fetch
    rst = 0; pc_ld = 0; run = 1; mem_req_ready = 1; p0 = pulses;
    step();
    chk("t1_req_valid", mem_req_valid, 1);
    chk("t1_req_addr", mem_req_addr, 24'h000010);
    chk("t1_pc_handle_req", pc_handle, 0);
    step();
    chk("t1_wait_no_valid", mem_req_valid, 0);
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF; #1;
    chk("t1_pc_handle", pc_handle, 1);
    step(); mem_rsp_valid = 0;
    chk("t1_ir_valid", ir_valid, 1);
    chk("t1_ir_data", ir_data, 32'hDEADBEEF);
    chk("t1_ir_pc", ir_pc, 24'h000010);
    chk("t1_pc_inc", pc, 24'h000011);
    chk("t1_pulses", pulses - p0, 1);
    mem_req_ready = 0;
    step();
    chk("t1_next_valid", mem_req_valid, 1);
    chk("t1_next_addr", mem_req_addr, 24'h000011);
    chk("t1_ir_cleared", ir_valid, 0);
    // memory not ready, run dropped mid-request
    for (int i = 0; i < 5; i++) begin
      if (i == 2) run = 0;
      chk("t2_valid", mem_req_valid, 1);
      chk("t2_addr", mem_req_addr, 24'h000011);
      chk("t2_pc_handle", pc_handle, 0);
      step();
    end
    chk("t2_valid_after", mem_req_valid, 1);
    mem_req_ready = 1;
    step(); mem_req_ready = 0;
    d1 = $urandom; mem_rsp_valid = 1; mem_rsp_data = d1; #1;
    chk("t2_pc_handle_rsp", pc_handle, 1);
    step(); mem_rsp_valid = 0;
    // decode stalls in HOLD
    ir_ready = 0; run = 1; p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ir_valid", ir_valid, 1);
      chk("t3_ir_data", ir_data, d1);
      chk("t3_ir_pc", ir_pc, 24'h000011);
      chk("t3_no_req", mem_req_valid, 0);
      chk("t3_pc_once", pc, 24'h000012);
      step();
    end
    chk("t3_no_extra_pulse", pulses - p0, 0);
    ir_ready = 1;
    step();
    chk("t3_next_addr", mem_req_addr, 24'h000012);
    chk("t3_next_valid", mem_req_valid, 1);
    // timeout with no response
    mem_req_ready = 1;
    step(); mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_fault_yet", fault, 0);
      step();
    end
    chk("t4_no_fault_cycle4", fault, 0);
    step();
    chk("t4_fault", fault, 1);
    chk("t4_req_valid", mem_req_valid, 0);
    chk("t4_ir_valid", ir_valid, 0);
    mem_rsp_valid = 1; mem_rsp_data = 32'h12345678; #1;
    chk("t4_late_pc_handle", pc_handle, 0);
    step(); mem_rsp_valid = 0;
    chk("t4_fault_sticky", fault, 1);
    chk("t4_ir_still_empty", ir_valid, 0);
    chk("t4_pc_unchanged", pc, 24'h000012);
    rst = 1; #1;
    chk("t4_rst_clears_fault", fault, 0);
    chk("t4_rst_req_valid", mem_req_valid, 0);
    run = 0; pc_ld = 1; pc_ld_val = 24'hFFFFFF;
    step(); rst = 0;
    step(); pc_ld = 0; run = 1;
    step();
    chk("t5_req_addr", mem_req_addr, 24'hFFFFFF);
    // response on the last allowed WAIT cycle, with PC wrap
    mem_req_ready = 1;
    step(); mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_fault", fault, 0);
      step();
    end
    d2 = $urandom; mem_rsp_valid = 1; mem_rsp_data = d2; #1;
    chk("t5_pc_handle", pc_handle, 1);
    step(); mem_rsp_valid = 0;
    chk("t5_no_fault_after", fault, 0);
    chk("t5_ir_valid", ir_valid, 1);
    chk("t5_ir_data", ir_data, d2);
    chk("t5_ir_pc", ir_pc, 24'hFFFFFF);
    chk("t5_pc_wrap", pc, 24'h000000);
    ir_ready = 0; mem_rsp_valid = 1; mem_rsp_data = ~d2; #1;
    chk("t5_hold_spurious_pc_handle", pc_handle, 0);
    step(); mem_rsp_valid = 0;
    chk("t5_hold_ir_valid", ir_valid, 1);
    chk("t5_hold_ir_data", ir_data, d2);
    chk("t5_hold_no_req", mem_req_valid, 0);
    chk("t5_hold_pc", pc, 24'h000000);
    run = 0; ir_ready = 1;
    step();
    chk("t5_idle_ir_valid", ir_valid, 0);
    mem_rsp_valid = 1; #1;
    chk("t5_idle_spurious_pc_handle", pc_handle, 0);
    step(); mem_rsp_valid = 0;
    chk("t5_idle_no_req", mem_req_valid, 0);
    chk("t5_idle_ir_valid2", ir_valid, 0);
    chk("t5_idle_pc", pc, 24'h000000);
    // reset while waiting, response arrives afterwards
    run = 1;
    step();
    chk("t6_req_addr", mem_req_addr, 24'h000000);
    mem_req_ready = 1;
    step(); mem_req_ready = 0; run = 0; rst = 1; #1;
    chk("t6_rst_req_valid", mem_req_valid, 0);
    chk("t6_rst_req_addr", mem_req_addr, 0);
    chk("t6_rst_ir_valid", ir_valid, 0);
    chk("t6_rst_ir_data", ir_data, 0);
    chk("t6_rst_ir_pc", ir_pc, 0);
    chk("t6_rst_fault", fault, 0);
    step(); rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D; #1;
    chk("t6_pc_handle", pc_handle, 0);
    step(); mem_rsp_valid = 0;
    chk("t6_idle_req_valid", mem_req_valid, 0);
    chk("t6_idle_ir_valid", ir_valid, 0);
    chk("t6_idle_ir_data", ir_data, 0);
    chk("t6_pc", pc, 24'h000000);
    // randomized back-to-back fetches against the transaction model
    pc_ld = 1; pc_ld_val = 24'hFFFFF0 | 24'($urandom_range(0, 15));
    step(); pc_ld = 0; exp_pc = pc_ld_val; run = 1;
    step();
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 3); d = $urandom_range(0, 3); h = $urandom_range(0, 3);
      chk("rnd_req_valid", mem_req_valid, 1);
      chk("rnd_req_addr", mem_req_addr, exp_pc);
      repeat (r) begin
        step();
        chk("rnd_req_hold_addr", mem_req_addr, exp_pc);
      end
      mem_req_ready = 1;
      step(); mem_req_ready = 0;
      repeat (d) begin
        chk("rnd_wait_pc_handle", pc_handle, 0);
        step();
      end
      dr = $urandom; mem_rsp_valid = 1; mem_rsp_data = dr; #1;
      chk("rnd_pc_handle", pc_handle, 1);
      step(); mem_rsp_valid = 0;
      chk("rnd_fault", fault, 0);
      chk("rnd_ir_valid", ir_valid, 1);
      chk("rnd_ir_data", ir_data, dr);
      chk("rnd_ir_pc", ir_pc, exp_pc);
      exp_pc = exp_pc + 24'd1;
      chk("rnd_pc", pc, exp_pc);
      ir_ready = 0;
      repeat (h) begin
        step();
        chk("rnd_hold_ir_valid", ir_valid, 1);
      end
      ir_ready = 1;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
